shader_loader: RTL

SHADER_LOADER -- requirements
Module: shader_loader

---
 rtl/tiny_shader_pkg.sv | 14 +
 rtl/synchronizer.sv | 23 ++
 rtl/shader_loader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tiny_shader_pkg.sv
// Shared definitions for the tiny shader core: flash loader states and opcodes.
package tiny_shader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DATA,
      FINISH
   } state_t;

   localparam logic [7:0] FLASH_READ_OP = 8'h03;

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchroniser for a single asynchronous input bit.
module synchronizer #(
   parameter int FF_COUNT = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic [FF_COUNT-1:0] stages;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stages <= '0;
      end else begin
         stages <= {stages[FF_COUNT-2:0], din};
      end
   end

   assign dout = stages[FF_COUNT-1];

endmodule

// File: rtl/shader_loader.sv
// Boot loader: reads NUM_INSTR bytes from SPI flash (mode 0, opcode 03h) and
// streams them into shader memory with load/shift strobes.
module shader_loader
   import tiny_shader_pkg::*;
#(
   parameter int          NUM_INSTR  = 16,
   parameter int          CLK_DIV    = 2,
   parameter logic [23:0] START_ADDR = 24'h000000,
   parameter bit          AUTO_BOOT  = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   output logic       spi_sclk_o,
   output logic       spi_cs_no,
   output logic       spi_mosi_o,
   input  logic       spi_miso_i,
   output logic [7:0] memory_instr_o,
   output logic       memory_load_o,
   output logic       memory_shift_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam int TOTAL_BITS = 32 + 8 * NUM_INSTR;
   localparam int BIT_W      = $clog2(TOTAL_BITS) + 1;
   localparam int BYTE_W     = $clog2(NUM_INSTR + 1);
   localparam int DIV_W      = $clog2(CLK_DIV);

   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(TOTAL_BITS);
   localparam logic [BIT_W-1:0]  CMD_END   = BIT_W'(7);
   localparam logic [BIT_W-1:0]  ADDR_END  = BIT_W'(31);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_INSTR - 1);

   state_t              state;
   logic [DIV_W-1:0]    div_cnt;
   logic [BIT_W-1:0]    bit_cnt;
   logic [BYTE_W-1:0]   byte_cnt;
   logic [31:0]         tx_shift;
   logic [7:0]          rx_shift;
   logic                byte_ready;
   logic                shift_pending;
   logic                boot_pending;
   logic                miso_sync;
   logic                tick;

   synchronizer #(
      .FF_COUNT(2)
   ) u_miso_sync (
      .clk  (clk_i),
      .rst_n(rst_ni),
      .din  (spi_miso_i),
      .dout (miso_sync)
   );

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state          <= IDLE;
         div_cnt        <= '0;
         bit_cnt        <= '0;
         byte_cnt       <= '0;
         tx_shift       <= '0;
         rx_shift       <= '0;
         byte_ready     <= 1'b0;
         shift_pending  <= 1'b0;
         boot_pending   <= AUTO_BOOT;
         spi_sclk_o     <= 1'b0;
         spi_cs_no      <= 1'b1;
         spi_mosi_o     <= 1'b0;
         memory_instr_o <= '0;
         memory_load_o  <= 1'b0;
         memory_shift_o <= 1'b0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
      end else begin
         memory_load_o  <= 1'b0;
         memory_shift_o <= 1'b0;
         done_o         <= 1'b0;

         // Byte hand-off: load strobe one cycle after the 8th bit, shift the cycle after.
         if (byte_ready) begin
            memory_load_o  <= 1'b1;
            memory_instr_o <= rx_shift;
            byte_ready     <= 1'b0;
            shift_pending  <= 1'b1;
         end
         if (shift_pending) begin
            memory_shift_o <= 1'b1;
            shift_pending  <= 1'b0;
            byte_cnt       <= byte_cnt + 1'b1;
         end

         case (state)
            IDLE: begin
               spi_sclk_o <= 1'b0;
               spi_cs_no  <= 1'b1;
               spi_mosi_o <= 1'b0;
               busy_o     <= 1'b0;
               // busy_o is still high in the done cycle, so a start there is dropped too.
               if ((start_i || boot_pending) && !busy_o) begin
                  boot_pending <= 1'b0;
                  state        <= CMD;
                  spi_cs_no    <= 1'b0;
                  busy_o       <= 1'b1;
                  div_cnt      <= '0;
                  bit_cnt      <= '0;
                  byte_cnt     <= '0;
                  spi_mosi_o   <= FLASH_READ_OP[7];
                  tx_shift     <= {FLASH_READ_OP[6:0], START_ADDR, 1'b0};
               end
            end

            CMD, ADDR, DATA: begin
               div_cnt <= tick ? '0 : div_cnt + 1'b1;
               if (tick && !spi_sclk_o && (bit_cnt != LAST_BIT)) begin
                  spi_sclk_o <= 1'b1;
                  bit_cnt    <= bit_cnt + 1'b1;
                  if (state == DATA) begin
                     rx_shift   <= {rx_shift[6:0], miso_sync};
                     byte_ready <= (bit_cnt[2:0] == 3'd7);
                  end
                  if ((state == CMD) && (bit_cnt == CMD_END)) begin
                     state <= ADDR;
                  end
                  if ((state == ADDR) && (bit_cnt == ADDR_END)) begin
                     state <= DATA;
                  end
               end else if (tick && spi_sclk_o) begin
                  spi_sclk_o <= 1'b0;
                  spi_mosi_o <= tx_shift[31];
                  tx_shift   <= {tx_shift[30:0], 1'b0};
               end
               if ((state == DATA) && shift_pending && (byte_cnt == LAST_BYTE)) begin
                  state <= FINISH;
               end
            end

            FINISH: begin
               div_cnt <= tick ? '0 : div_cnt + 1'b1;
               if (tick) begin
                  if (spi_sclk_o) begin
                     spi_sclk_o <= 1'b0;
                  end else begin
                     spi_cs_no <= 1'b1;
                     done_o    <= 1'b1;
                     state     <= IDLE;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
